// File: rtl/axi_sram_slave_pkg.sv
// rtl/axi_sram_slave_pkg.sv - AXI3 SRAM responder encodings and FSM state types
package axi_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/axi_sram_addr_gen.sv
// rtl/axi_sram_addr_gen.sv - next word index for FIXED/INCR bursts, wrapping at memory depth
module axi_sram_addr_gen #(
    parameter int IDXW = 10
) (
    input  logic [IDXW-1:0] idx_i,
    input  logic            fixed_i,
    output logic [IDXW-1:0] next_idx_o
);

    // Index width equals log2 of the depth, so the natural carry-out gives the wrap.
    assign next_idx_o = fixed_i ? idx_i : idx_i + {{(IDXW-1){1'b0}}, 1'b1};

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 32-bit responder backed by a word-addressed register array
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int READ_DELAY  = 1,
    parameter int STALL_EVERY = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         IDXW   = $clog2(MEM_WORDS);
    localparam logic [3:0] RD_DLY = 4'(READ_DELAY - 1);

    logic [31:0] mem_q [MEM_WORDS];

    r_state_t        r_state_q, r_state_d;
    logic [3:0]      rid_q, rid_d;
    logic [IDXW-1:0] ridx_q, ridx_d, ridx_next;
    logic [7:0]      rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic            rfixed_q, rfixed_d;
    logic [3:0]      rdly_q, rdly_d;

    w_state_t        w_state_q, w_state_d;
    logic [3:0]      bid_q, bid_d;
    logic [IDXW-1:0] widx_q, widx_d, widx_next;
    logic [7:0]      wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic            wfixed_q, wfixed_d;
    logic            werr_q, werr_d;

    // Size, wid and out-of-range address bits carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, wid, araddr[31:IDXW+2], araddr[1:0],
                         awaddr[31:IDXW+2], awaddr[1:0]};

    axi_sram_addr_gen #(.IDXW(IDXW)) u_rd_addr (
        .idx_i      (ridx_q),
        .fixed_i    (rfixed_q),
        .next_idx_o (ridx_next)
    );

    axi_sram_addr_gen #(.IDXW(IDXW)) u_wr_addr (
        .idx_i      (widx_q),
        .fixed_i    (wfixed_q),
        .next_idx_o (widx_next)
    );

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rlast   = (r_state_q == R_DATA) && (rbeat_q == rlen_q);
    assign rdata   = mem_q[ridx_q];
    assign rid     = rid_q;
    assign rresp   = RESP_OKAY;

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rfixed_d  = rfixed_q;
        rdly_d    = rdly_q;
        case (r_state_q)
            R_IDLE: if (arvalid) begin
                rid_d     = arid;
                ridx_d    = araddr[IDXW+1:2];
                rlen_d    = arlen;
                rbeat_d   = 8'd0;
                rfixed_d  = (arburst == BURST_FIXED);
                rdly_d    = RD_DLY;
                r_state_d = R_WAIT;
            end
            R_WAIT: begin
                if (rdly_q == 4'd0) r_state_d = R_DATA;
                else                rdly_d    = rdly_q - 4'd1;
            end
            R_DATA: if (rready) begin
                if (rlast) begin
                    r_state_d = R_IDLE;
                end else begin
                    rbeat_d = rbeat_q + 8'd1;
                    ridx_d  = ridx_next;
                    if (STALL_EVERY != 0) begin
                        rdly_d    = RD_DLY;
                        r_state_d = R_WAIT;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        wfixed_d  = wfixed_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: if (awvalid) begin
                bid_d     = awid;
                widx_d    = awaddr[IDXW+1:2];
                wlen_d    = awlen;
                wbeat_d   = 8'd0;
                wfixed_d  = (awburst == BURST_FIXED);
                werr_d    = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (wvalid) begin
                // awlen defines the burst; a misplaced wlast only flags the response.
                if (wlast != (wbeat_q == wlen_q)) werr_d = 1'b1;
                widx_d  = widx_next;
                wbeat_d = wbeat_q + 8'd1;
                if (wbeat_q == wlen_q) w_state_d = W_RESP;
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rid_q     <= 4'd0;
            ridx_q    <= '0;
            rlen_q    <= 8'd0;
            rbeat_q   <= 8'd0;
            rfixed_q  <= 1'b0;
            rdly_q    <= 4'd0;
            w_state_q <= W_IDLE;
            bid_q     <= 4'd0;
            widx_q    <= '0;
            wlen_q    <= 8'd0;
            wbeat_q   <= 8'd0;
            wfixed_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rfixed_q  <= rfixed_d;
            rdly_q    <= rdly_d;
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            wfixed_q  <= wfixed_d;
            werr_q    <= werr_d;
        end
    end

    // Contents survive reset; the combinational read port sees the pre-edge value.
    always_ff @(posedge aclk) begin
        if (w_state_q == W_DATA && wvalid) begin
            for (int j = 0; j < 4; j++) begin
                if (wstrb[j]) mem_q[widx_q][8*j +: 8] <= wdata[8*j +: 8];
            end
        end
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) with 32-bit data and an internal word-addressed register-array memory.
- Serves the burst reads issued by the cache AXI read-port merger and the writes from the data cache.
- Used as the simulation/bring-up memory behind the CPU's single AXI master port.
- Read and write channels run independent FSMs; only FIXED and INCR bursts are supported.

Parameters:
MEM_WORDS, 1024, memory depth in 32-bit words (power of two); word index = addr[log2(MEM_WORDS)+1:2], higher bits ignored (aliasing).
READ_DELAY, 1, cycles from AR handshake to first rvalid (1..15); also the gap inserted before every beat after the first when STALL_EVERY=1.
STALL_EVERY, 0, 1 = insert READ_DELAY idle cycles between read beats (stress mode).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read start byte address
arlen  in  8  beats-1
arsize  in  3  must be 3'b010; other values are treated as 3'b010
arburst  in  2  00 FIXED, 01 INCR, other values treated as INCR
arvalid / arready  in / out  1  AR handshake
rid  out  4  echo of latched arid
rdata  out  32  read data
rresp  out  2  always 2'b00
rlast  out  1  final beat
rvalid / rready  out / in  1  R handshake
awid, awaddr, awlen, awsize, awburst  in  4, 32, 8, 3, 2  same meaning as the AR fields
awvalid / awready  in / out  1  AW handshake
wid  in  4  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last-beat marker from master
wvalid / wready  in / out  1  W handshake
bid  out  4  echo of latched awid
bresp  out  2  00 OKAY, 10 SLVERR
bvalid / bready  out / in  1  B handshake

Behaviour:
- Reset (aresetn low, asynchronous): read FSM to R_IDLE, write FSM to W_IDLE.
  - Reset values: arready=1, rvalid=0, rlast=0, rid=0, awready=1, wready=0, bvalid=0, bid=0, bresp=0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no partial response is emitted afterwards.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/burst, clear beat counter, load delay counter with READ_DELAY-1, go to R_WAIT (arready=0).
  - R_WAIT: delay counter decrements; at 0 go to R_DATA.
  - R_DATA: rvalid=1, rdata=mem[beat word index] combinational, rlast=(beat==len).
  - rvalid, rdata, rlast and rid stay stable while rready=0.
  - On rvalid&rready with rlast: go to R_IDLE, arready=1 from the next cycle. No back-to-back AR accept in the same cycle.
  - On rvalid&rready without rlast: beat+1; INCR advances the word index by 1, wrapping modulo MEM_WORDS; FIXED holds the index. Stay in R_DATA, or go to R_WAIT if STALL_EVERY=1.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst, clear beat counter and error flag, go to W_DATA.
  - W_DATA: wready=1. On each W handshake, write the bytes whose wstrb bit is set into mem[word index]; the write is visible to reads from the next cycle. Advance the index as for reads.
  - Burst length is set by awlen, not wlast: if wlast != (beat==awlen) on any beat, set the error flag.
  - After beat==awlen is accepted, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp = error ? 10 : 00; held until bready. Then go to W_IDLE.
- Read and write may be active in the same cycle. A read of the word written in that cycle returns the old data (write-after-read ordering).
- W data arriving before the AW handshake is not accepted: wready=0 outside W_DATA.
- arlen=0 gives a single beat with rlast=1; arlen=255 gives 256 beats, with the counter 8 bits wide (no overflow past len).

Decomposition:
- Shared package/header (alongside the cache config constants): burst encodings (FIXED/INCR), resp encodings (OKAY/SLVERR), the state encodings for both FSMs, and the fixed SIZE_4B constant.
- One natural sub-module: axi_sram_addr_gen (next word index from the current index, burst type and MEM_WORDS wrap), instantiated once per channel.

Test Plan:
- Preload mem[0..7]=0x100+i; AR addr=0x0, len=7, INCR, rready=1 -> first rvalid 1 cycle after the AR handshake, 8 beats 0x100..0x107, rlast only on beat 8, rid echoed.
- AR addr=0x10, len=3, FIXED -> 4 beats all equal to mem[4]. Repeat with rready toggling every other cycle -> rdata/rlast held stable while stalled.
- AW addr=0x20, len=3; W data 0xA0..0xA3, wstrb=4'b1111, wlast on beat 4 -> bvalid with bresp=00. Then read back len=3 -> 0xA0..0xA3.
- Single-beat write 0xDEADBEEF with wstrb=4'b0101 over a word holding 0x11223344 -> reads back 0x11AD33EF.
- Write len=1 with wlast asserted on beat 1 -> 2 beats still accepted, bresp=10, memory updated for both beats.
- Assert aresetn low during beat 3 of an 8-beat read -> rvalid=0 and arready=1 immediately; a new read after release completes normally with correct data.
